// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 keypad row scanner with frame debounce and one-hot key report
module keypad_scanner #(
  parameter int SCAN_CNT       = 1024,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  key_col,
  output logic [3:0]  key_row,
  output logic [11:0] scan_data,
  output logic        valid,
  output logic        key_pressed
);

  localparam int CW = $clog2(SCAN_CNT);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(SCAN_CNT - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic {RELEASED, HELD} state_t;

  state_t        state;
  logic [2:0]    col_s1, col_s2;
  logic [CW-1:0] cnt;
  logic [1:0]    row_idx;
  logic [8:0]    raw;
  logic [11:0]   prev_frame;
  logic          prev_ok;
  logic [SW-1:0] stable_cnt;

  logic          wrap, frame_done, same, accept, one_hot;
  logic [11:0]   new_frame;
  logic [SW-1:0] stable_next;

  // Row 3 is sampled directly into the completed frame, so no sample is lost on the wrap cycle.
  always_comb begin
    wrap        = (cnt == CNT_MAX);
    frame_done  = wrap && (row_idx == 2'd3);
    new_frame   = {~col_s2, raw};
    same        = prev_ok && (new_frame == prev_frame);
    stable_next = SW'(1);
    if (same)
      stable_next = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
    accept  = frame_done && (stable_next == STABLE_MAX) && !(same && stable_cnt == STABLE_MAX);
    one_hot = (new_frame != 12'd0) && ((new_frame & (new_frame - 12'd1)) == 12'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RELEASED;
      col_s1      <= 3'b111;
      col_s2      <= 3'b111;
      cnt         <= '0;
      row_idx     <= 2'd0;
      key_row     <= 4'b1110;
      raw         <= '0;
      prev_frame  <= '0;
      prev_ok     <= 1'b0;
      stable_cnt  <= '0;
      scan_data   <= '0;
      valid       <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      col_s1 <= key_col;
      col_s2 <= col_s1;
      valid  <= 1'b0;

      if (wrap) begin
        cnt     <= '0;
        row_idx <= row_idx + 2'd1;
        key_row <= {key_row[2:0], key_row[3]};
        case (row_idx)
          2'd0:    raw[2:0] <= ~col_s2;
          2'd1:    raw[5:3] <= ~col_s2;
          2'd2:    raw[8:6] <= ~col_s2;
          default: ;
        endcase
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (frame_done) begin
        prev_frame <= new_frame;
        prev_ok    <= 1'b1;
        stable_cnt <= stable_next;
      end

      // Multi-key frames lock the FSM in HELD until a debounced all-released frame.
      if (accept) begin
        case (state)
          RELEASED: begin
            if (new_frame != 12'd0) begin
              state       <= HELD;
              key_pressed <= 1'b1;
              if (one_hot) begin
                valid     <= 1'b1;
                scan_data <= new_frame;
              end
            end
          end
          HELD: begin
            if (new_frame == 12'd0) begin
              state       <= RELEASED;
              key_pressed <= 1'b0;
            end
          end
          default: state <= RELEASED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner with SCAN_CNT=8, DEBOUNCE_SCANS=3
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  key_col;
  logic [3:0]  key_row;
  logic [11:0] scan_data;
  logic        valid;
  logic        key_pressed;

  logic [11:0] keys = 12'd0;
  int n_cmp = 0;
  int n_bad = 0;
  int vcount = 0;
  int cons_cnt = 0;
  logic prev_valid = 1'b0;
  int v0;

  keypad_scanner #(.SCAN_CNT(8), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst(rst), .key_col(key_col), .key_row(key_row),
    .scan_data(scan_data), .valid(valid), .key_pressed(key_pressed)
  );

  always #5 clk = ~clk;

  // Passive matrix: a closed key pulls its column low while its row is driven low.
  always_comb begin
    key_col = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!key_row[r] && keys[r*3+c]) key_col[c] = 1'b0;
  end

  always @(posedge clk) begin
    if (valid) vcount <= vcount + 1;
    if (valid && prev_valid) cons_cnt <= cons_cnt + 1;
    prev_valid <= valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int bound, input string tag);
    int n = 0;
    while (valid !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    cycles(3);
    check("rst_key_row", {28'd0, key_row}, 32'h0000000e);
    check("rst_scan_data", {20'd0, scan_data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_key_pressed", {31'd0, key_pressed}, 32'd0);
    rst = 1'b1;

    // 1: idle row rotation
    for (int n = 1; n <= 64; n++) begin
      logic [3:0] e;
      @(negedge clk);
      e = ~(4'b0001 << ((n / 8) % 4));
      check("idle_row", {28'd0, key_row}, {28'd0, e});
    end
    cycles(96);
    check("idle_no_valid", vcount, 0);
    check("idle_scan_data", {20'd0, scan_data}, 32'd0);

    // 2: press '5'
    v0 = vcount;
    keys = 12'h010;
    wait_valid(148, "t2_valid_latency");
    check("t2_data", {20'd0, scan_data}, 32'h010);
    cycles(2);
    check("t2_pressed", {31'd0, key_pressed}, 32'd1);
    cycles(170);
    check("t2_one_pulse", vcount - v0, 1);
    keys = 12'd0;
    cycles(40);
    check("t2_still_pressed", {31'd0, key_pressed}, 32'd1);
    cycles(100);
    check("t2_released", {31'd0, key_pressed}, 32'd0);
    check("t2_data_hold", {20'd0, scan_data}, 32'h010);

    // 3: bouncing '#', then '0'
    v0 = vcount;
    for (int i = 0; i < 14; i++) begin
      keys = (i % 2 == 0) ? 12'h800 : 12'h000;
      cycles(5);
    end
    keys = 12'h800;
    wait_valid(148, "t3_hash_valid");
    check("t3_hash_data", {20'd0, scan_data}, 32'h800);
    cycles(100);
    check("t3_one_pulse", vcount - v0, 1);
    keys = 12'd0;
    cycles(160);
    v0 = vcount;
    keys = 12'h400;
    wait_valid(148, "t3_zero_valid");
    check("t3_zero_data", {20'd0, scan_data}, 32'h400);
    cycles(3);
    check("t3_zero_count", vcount - v0, 1);
    keys = 12'd0;
    cycles(160);

    // 4: two keys together are locked out
    v0 = vcount;
    keys = 12'h005;
    cycles(192);
    check("t4_no_valid", vcount - v0, 0);
    check("t4_pressed", {31'd0, key_pressed}, 32'd1);
    check("t4_data_kept", {20'd0, scan_data}, 32'h400);
    keys = 12'd0;
    cycles(160);
    check("t4_released", {31'd0, key_pressed}, 32'd0);
    keys = 12'h004;
    wait_valid(148, "t4_three_valid");
    check("t4_three_data", {20'd0, scan_data}, 32'h004);
    keys = 12'd0;
    cycles(160);

    // 5: roll-over from '7' to '9' is not reported
    v0 = vcount;
    keys = 12'h040;
    wait_valid(148, "t5_seven_valid");
    check("t5_seven_data", {20'd0, scan_data}, 32'h040);
    cycles(40);
    keys = 12'h140;
    cycles(96);
    keys = 12'h100;
    cycles(160);
    check("t5_no_nine", vcount - v0, 1);
    check("t5_data_kept", {20'd0, scan_data}, 32'h040);
    check("t5_pressed", {31'd0, key_pressed}, 32'd1);
    keys = 12'd0;
    cycles(160);
    check("t5_released", {31'd0, key_pressed}, 32'd0);

    // 6: reset while '2' is held
    keys = 12'h002;
    wait_valid(148, "t6_two_valid");
    check("t6_two_data", {20'd0, scan_data}, 32'h002);
    cycles(50);
    rst = 1'b0;
    cycles(1);
    check("t6_rst_data", {20'd0, scan_data}, 32'd0);
    check("t6_rst_pressed", {31'd0, key_pressed}, 32'd0);
    check("t6_rst_row", {28'd0, key_row}, 32'h0000000e);
    rst = 1'b1;
    v0 = vcount;
    wait_valid(148, "t6_revalid");
    check("t6_revalid_data", {20'd0, scan_data}, 32'h002);
    cycles(3);
    check("t6_revalid_count", vcount - v0, 1);
    keys = 12'd0;
    cycles(10);

    check("never_consecutive", cons_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 4-row x 3-column active-low keypad matrix and samples its columns.
- Debounces the key state and reports each new single-key press as a one-hot 12-bit code with a one-cycle valid strobe.
- Its outputs feed scan_data/valid of display_seg directly; it is the producer side of that interface.
- No auto-repeat: one press yields exactly one valid pulse.

Parameters:
- SCAN_CNT, 1024, clock cycles each row is driven (dwell); legal range >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full-matrix frames required to accept a key state; legal range >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-low.
- key_col  input  3  column sense lines; active-low, externally pulled up; asynchronous to clk.
- key_row  output  4  row drive; active-low, exactly one bit low at any time.
- scan_data  output  12  one-hot code of the last reported key.
- valid  output  1  one-cycle strobe; scan_data is new on this cycle.
- key_pressed  output  1  high while the debounced state is "key(s) down" (FSM state HELD).

Behaviour:
- Reset (rst low at posedge clk): key_row=4'b1110, scan_data=0, valid=0, key_pressed=0. Dwell counter, row index, frame buffers and stable counter are cleared. Synchronizer flops are set to 3'b111. FSM enters RELEASED. Reset mid-press discards all history.
- key_col passes through a 2-flop synchronizer before use.
- Row scan:
  - The dwell counter runs 0..SCAN_CNT-1. Row index r advances 0,1,2,3,0 when the counter wraps.
  - key_row = ~(1<<r), registered.
  - The synchronized columns are sampled on the cycle where counter == SCAN_CNT-1.
- Key map: row r, column c (c=0 is key_col[0]) sets raw bit r*3+c when that column reads low.
  - Row 0: bits 0,1,2 = keys 1,2,3.
  - Row 1: bits 3,4,5 = keys 4,5,6.
  - Row 2: bits 6,7,8 = keys 7,8,9.
  - Row 3: bit 9 = *, bit 10 = 0, bit 11 = #.
  - This encoding is exactly what display_seg decodes.
- Frame: the raw 12-bit frame is complete on the row-3 sample cycle (frame period 4*SCAN_CNT). On completion:
  - Compare the new frame with the previous frame.
  - Equal: stable_cnt increments, saturating at DEBOUNCE_SCANS.
  - Different: stable_cnt = 1.
  - Store the new frame as the previous frame.
  - The first frame after reset counts as a change.
- Acceptance: the frame is "debounced" on the completion cycle where stable_cnt reaches DEBOUNCE_SCANS (the transition only, not every saturated frame).
- FSM (evaluated on debounced events only), 2 states:
  - RELEASED, debounced frame = 0: stay.
  - RELEASED, debounced frame one-hot: on the next cycle valid=1 and scan_data=frame; go HELD.
  - RELEASED, debounced frame with more than one bit set: go HELD, no valid, scan_data unchanged (locked until full release).
  - HELD, debounced frame = 0: go RELEASED.
  - HELD, any other debounced frame (key change or added key while held): stay, no valid. A new key is reported only after a full release.
- Latency: valid rises exactly 1 cycle after the accepting frame-completion cycle. Worst case from a clean steady press to valid is (DEBOUNCE_SCANS+1)*4*SCAN_CNT+4 cycles.
- valid is high for exactly 1 cycle and never on consecutive cycles. scan_data holds its value until the next valid or reset.
- key_pressed = (state == HELD), registered.
- Counter wrap and frame completion on the same cycle: row advance and frame evaluation both take effect; no sample is lost.
- Widths: dwell counter is $clog2(SCAN_CNT) bits; stable_cnt is $clog2(DEBOUNCE_SCANS+1) bits.

Test Plan:
All scenarios use SCAN_CNT=8 and DEBOUNCE_SCANS=3 (frame = 32 cycles).
1. Release reset and leave no key pressed -> key_row cycles 1110,1101,1011,0111 for 8 cycles each, repeating; valid never asserts; scan_data=0.
2. Model press '5' (key_col[1] low while key_row[1] low), held for 10 frames -> exactly one valid pulse with scan_data=12'h010 within 148 cycles of press; key_pressed=1 until 3 frames after release.
3. Bounce '#': toggle contact every 5 cycles for 70 cycles, then hold steady -> exactly one valid, scan_data=12'h800. Release for 4 frames, then press '0' -> second valid, scan_data=12'h400.
4. Press '1' and '3' together for 6 frames -> no valid, key_pressed=1, scan_data keeps its prior value. Release for 4 frames, then press '3' -> valid, scan_data=12'h004.
5. Press '7', then while it is held press '9' and release '7' -> only the 12'h040 report; no valid for '9' until all keys are released.
6. With '2' held and already reported, pull rst low for 1 cycle -> next edge scan_data=0, key_pressed=0, key_row=1110; with '2' still held, a fresh valid with scan_data=12'h002 follows within 148 cycles.
